axi_mem_param: RTL and testbench
================================

Name:
axi_mem_param

Overview:
Parametrised AXI4 slave memory model, the successor to the fixed 256-bit/6-bit-id memory stub. It serves independent read and write channels from a DEPTH-word array, supports FIXED/INCR/WRAP bursts and byte strobes, and returns SLVERR for out-of-range or malformed bursts. It is used as the DRAM stand-in behind the back-propagation datapath in simulation and FPGA builds.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 256, data width (power of 2, >= 32); BYTES = DATA_W/8
ID_W, 6, transaction id width
DEPTH, 4096, memory words of DATA_W; word index = addr >> log2(BYTES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
axis_r_ar_valid  in  1  read address valid
axis_r_ar_ready  out  1  read address ready
axis_r_ar_payload_addr  in  ADDR_W  burst start byte address
axis_r_ar_payload_id  in  ID_W  read id
axis_r_ar_payload_len  in  8  beats minus 1
axis_r_ar_payload_burst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
axis_r_r_valid  out  1  read data valid
axis_r_r_ready  in  1  read data ready
axis_r_r_payload_data  out  DATA_W  read data
axis_r_r_payload_id  out  ID_W  echo of AR id
axis_r_r_payload_resp  out  2  0 OKAY, 2 SLVERR
axis_r_r_payload_last  out  1  final beat
axis_w_aw_valid  in  1  write address valid
axis_w_aw_ready  out  1  write address ready
axis_w_aw_payload_addr  in  ADDR_W  burst start byte address
axis_w_aw_payload_id  in  ID_W  write id
axis_w_aw_payload_len  in  8  beats minus 1
axis_w_aw_payload_burst  in  2  as AR burst
axis_w_w_valid  in  1  write data valid
axis_w_w_ready  out  1  write data ready
axis_w_w_payload_data  in  DATA_W  write data
axis_w_w_payload_strb  in  BYTES  byte enables
axis_w_w_payload_last  in  1  final beat marker
axis_w_b_valid  out  1  write response valid
axis_w_b_ready  in  1  write response ready
axis_w_b_payload_id  out  ID_W  echo of AW id
axis_w_b_payload_resp  out  2  0 OKAY, 2 SLVERR

Behaviour:
- Reset: all valid outputs 0, both ready outputs 0 while reset is high and 1 the cycle after (IDLE). Data/id/resp outputs are 0. Memory contents are not reset. Reset mid-burst aborts the burst silently; there is no B or R for it.
- Beat size is always BYTES and the low address bits are ignored. Address step per beat: FIXED 0, INCR +BYTES (no 4KB check). WRAP wraps within a (len+1)*BYTES aligned window. WRAP with len not in {1,3,7,15}, or burst=3, is treated as INCR with SLVERR.
- Read FSM: R_IDLE (ar_ready=1) -> R_DATA on the ar handshake; id/len/burst/addr are latched. In R_DATA, ar_ready=0 and r_valid=1 starting the cycle after acceptance (1-cycle latency).
- Read beats: the beat and address advance only on r_valid&&r_ready. Data/resp/last stay stable while stalled. r_last=1 on beat len. After the last handshake, return to R_IDLE; the next ar is accepted the following cycle.
- Read errors: a word index >= DEPTH gives data 0 and resp SLVERR for that beat only. A malformed burst gives SLVERR on every beat.
- Write FSM: W_IDLE (aw_ready=1) -> W_DATA (w_ready=1) -> W_RESP (b_valid=1) -> W_IDLE on b_ready.
- Write beats: each w handshake writes the bytes whose strb bit is set. Out-of-range beats are dropped and flag SLVERR.
- Write termination: exactly len+1 beats are accepted. A w_last mismatch (early or missing) flags SLVERR but does not change the beat count. b_resp is SLVERR if any beat or the burst flagged an error.
- Read/write collision: read and write channels run concurrently on a 1W1R array. A same-word read and write in the same cycle returns the old data (read-first).
- len=0 is a single beat with last=1. Maximum len=255 is supported.

Test Plan:
- Single write: AW addr 0x40, len 0, strb all ones, data D -> B OKAY, id echoed. Then AR addr 0x40 -> one R beat with data D, last=1, OKAY.
- Strobed INCR: write 4 beats at 0x0 with strb 0x0000000F on beat 2. Read back -> beat 2 has only the low 4 bytes updated and every other byte of beat 2 keeps its prior value.
- WRAP len 3 at word 2 (addr 0x40 with DATA_W=256) -> beats hit words 2, 3, 0, 1. WRAP with len 2 -> INCR order 2, 3, 4 and SLVERR on every beat.
- Out of range: AR at word DEPTH-1, INCR len 1 -> beat 0 OKAY with data, beat 1 data 0 and SLVERR.
- Backpressure: r_ready toggles 1,0,0,1 during an 8-beat read -> data/last are held while stalled, no beat is lost, and exactly 8 handshakes occur.
- w_last asserted on beat 1 of a len=3 burst -> 4 beats are still accepted and B returns SLVERR. Asserting reset during W_DATA -> b_valid stays 0 and aw_ready=1 after reset deasserts.

Source files
------------

// File: rtl/axi_mem_param.sv
`timescale 1ns/1ps
// Parametrised AXI4 slave memory model: independent read and write FSMs over a
// DEPTH-word 1W1R array with FIXED/INCR/WRAP bursts, byte strobes and SLVERR.
module axi_mem_param #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int ID_W   = 6,
    parameter int DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  axis_r_ar_valid,
    output logic                  axis_r_ar_ready,
    input  logic [ADDR_W-1:0]     axis_r_ar_payload_addr,
    input  logic [ID_W-1:0]       axis_r_ar_payload_id,
    input  logic [7:0]            axis_r_ar_payload_len,
    input  logic [1:0]            axis_r_ar_payload_burst,
    output logic                  axis_r_r_valid,
    input  logic                  axis_r_r_ready,
    output logic [DATA_W-1:0]     axis_r_r_payload_data,
    output logic [ID_W-1:0]       axis_r_r_payload_id,
    output logic [1:0]            axis_r_r_payload_resp,
    output logic                  axis_r_r_payload_last,
    input  logic                  axis_w_aw_valid,
    output logic                  axis_w_aw_ready,
    input  logic [ADDR_W-1:0]     axis_w_aw_payload_addr,
    input  logic [ID_W-1:0]       axis_w_aw_payload_id,
    input  logic [7:0]            axis_w_aw_payload_len,
    input  logic [1:0]            axis_w_aw_payload_burst,
    input  logic                  axis_w_w_valid,
    output logic                  axis_w_w_ready,
    input  logic [DATA_W-1:0]     axis_w_w_payload_data,
    input  logic [DATA_W/8-1:0]   axis_w_w_payload_strb,
    input  logic                  axis_w_w_payload_last,
    output logic                  axis_w_b_valid,
    input  logic                  axis_w_b_ready,
    output logic [ID_W-1:0]       axis_w_b_payload_id,
    output logic [1:0]            axis_w_b_payload_resp
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic is_malformed(input logic [7:0] len, input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        is_malformed = (burst == 2'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // Legal WRAP lengths are 2^n-1, so len is directly the wrap mask on the word index.
    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] word,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [WORD_W-1:0] mask;
        mask = WORD_W'(len);
        if (burst == BURST_FIXED)
            next_word = word;
        else if ((burst == BURST_WRAP) && !is_malformed(len, burst))
            next_word = (word & ~mask) | ((word + WORD_W'(1)) & mask);
        else
            next_word = word + WORD_W'(1);
    endfunction

    function automatic logic word_ok(input logic [WORD_W-1:0] word);
        word_ok = (word < WORD_W'(DEPTH));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    r_state_e          r_state_q;
    logic              ar_ready_q, r_valid_q, r_last_q, r_bad_q;
    logic [DATA_W-1:0] r_data_q;
    logic [ID_W-1:0]   r_id_q;
    logic [1:0]        r_resp_q, r_burst_q;
    logic [7:0]        r_len_q, r_beat_q;
    logic [WORD_W-1:0] r_word_q, r_word_d, ar_word_s;
    logic              r_word_ok_s, ar_bad_s;

    w_state_e          w_state_q;
    logic              aw_ready_q, w_ready_q, b_valid_q, w_err_q;
    logic [ID_W-1:0]   w_id_q, b_id_q;
    logic [1:0]        b_resp_q, w_burst_q;
    logic [7:0]        w_len_q, w_beat_q;
    logic [WORD_W-1:0] w_word_q, aw_word_s;
    logic              w_hs_s, w_word_ok_s, w_final_s, w_beat_err_s, mem_we_s;

    // Read-side address decode: the word fetched on acceptance or on the next beat.
    always_comb begin
        ar_word_s = WORD_W'(axis_r_ar_payload_addr >> OFF_W);
        ar_bad_s  = is_malformed(axis_r_ar_payload_len, axis_r_ar_payload_burst);
        if (r_state_q == R_IDLE)
            r_word_d = ar_word_s;
        else
            r_word_d = next_word(r_word_q, r_len_q, r_burst_q);
        r_word_ok_s = word_ok(r_word_d);
    end

    // Read FSM; data is fetched one beat ahead so outputs stay registered and read-first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_bad_q    <= 1'b0;
            r_data_q   <= '0;
            r_id_q     <= '0;
            r_resp_q   <= RESP_OKAY;
            r_burst_q  <= 2'd0;
            r_len_q    <= 8'd0;
            r_beat_q   <= 8'd0;
            r_word_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (axis_r_ar_valid && ar_ready_q) begin
                        r_state_q  <= R_DATA;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_id_q     <= axis_r_ar_payload_id;
                        r_len_q    <= axis_r_ar_payload_len;
                        r_burst_q  <= axis_r_ar_payload_burst;
                        r_bad_q    <= ar_bad_s;
                        r_word_q   <= r_word_d;
                        r_beat_q   <= 8'd0;
                        r_last_q   <= (axis_r_ar_payload_len == 8'd0);
                        r_data_q   <= r_word_ok_s ? mem_q[IDX_W'(r_word_d)] : '0;
                        r_resp_q   <= (ar_bad_s || !r_word_ok_s) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (axis_r_r_ready && r_valid_q) begin
                        if (r_last_q) begin
                            r_state_q  <= R_IDLE;
                            ar_ready_q <= 1'b1;
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                        end else begin
                            r_word_q <= r_word_d;
                            r_beat_q <= r_beat_q + 8'd1;
                            r_last_q <= ((r_beat_q + 8'd1) == r_len_q);
                            r_data_q <= r_word_ok_s ? mem_q[IDX_W'(r_word_d)] : '0;
                            r_resp_q <= (r_bad_q || !r_word_ok_s) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Write-side beat qualification and per-beat error detection.
    always_comb begin
        aw_word_s    = WORD_W'(axis_w_aw_payload_addr >> OFF_W);
        w_hs_s       = (w_state_q == W_DATA) && axis_w_w_valid && w_ready_q;
        w_word_ok_s  = word_ok(w_word_q);
        w_final_s    = (w_beat_q == w_len_q);
        w_beat_err_s = !w_word_ok_s || (axis_w_w_payload_last != w_final_s);
        mem_we_s     = w_hs_s && w_word_ok_s && !reset;
    end

    // Write FSM; the beat count alone terminates the burst, w_last only flags errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            w_err_q    <= 1'b0;
            w_id_q     <= '0;
            b_id_q     <= '0;
            b_resp_q   <= RESP_OKAY;
            w_burst_q  <= 2'd0;
            w_len_q    <= 8'd0;
            w_beat_q   <= 8'd0;
            w_word_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    aw_ready_q <= 1'b1;
                    if (axis_w_aw_valid && aw_ready_q) begin
                        w_state_q  <= W_DATA;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        w_id_q     <= axis_w_aw_payload_id;
                        w_len_q    <= axis_w_aw_payload_len;
                        w_burst_q  <= axis_w_aw_payload_burst;
                        w_word_q   <= aw_word_s;
                        w_beat_q   <= 8'd0;
                        w_err_q    <= is_malformed(axis_w_aw_payload_len, axis_w_aw_payload_burst);
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        if (w_final_s) begin
                            w_state_q <= W_RESP;
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            b_id_q    <= w_id_q;
                            b_resp_q  <= (w_err_q || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            w_word_q <= next_word(w_word_q, w_len_q, w_burst_q);
                            w_beat_q <= w_beat_q + 8'd1;
                            w_err_q  <= w_err_q || w_beat_err_s;
                        end
                    end
                end
                W_RESP: begin
                    if (axis_w_b_ready) begin
                        w_state_q  <= W_IDLE;
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Byte-strobed memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (axis_w_w_payload_strb[b])
                    mem_q[IDX_W'(w_word_q)][b*8 +: 8] <= axis_w_w_payload_data[b*8 +: 8];
            end
        end
    end

    assign axis_r_ar_ready       = ar_ready_q;
    assign axis_r_r_valid        = r_valid_q;
    assign axis_r_r_payload_data = r_data_q;
    assign axis_r_r_payload_id   = r_id_q;
    assign axis_r_r_payload_resp = r_resp_q;
    assign axis_r_r_payload_last = r_last_q;
    assign axis_w_aw_ready       = aw_ready_q;
    assign axis_w_w_ready        = w_ready_q;
    assign axis_w_b_valid        = b_valid_q;
    assign axis_w_b_payload_id   = b_id_q;
    assign axis_w_b_payload_resp = b_resp_q;
endmodule

// File: tb/tb_axi_mem_param.sv
`timescale 1ns/1ps
// Directed bench for axi_mem_param: table-driven burst reads plus hand-written
// sequences for strobes, backpressure, w_last mismatch and mid-burst reset.
module tb_axi_mem_param;
    localparam int DEPTH = 4096;

    logic         clk = 1'b0;
    logic         reset;
    logic         axis_r_ar_valid, axis_r_ar_ready;
    logic [31:0]  axis_r_ar_payload_addr;
    logic [5:0]   axis_r_ar_payload_id;
    logic [7:0]   axis_r_ar_payload_len;
    logic [1:0]   axis_r_ar_payload_burst;
    logic         axis_r_r_valid, axis_r_r_ready;
    logic [255:0] axis_r_r_payload_data;
    logic [5:0]   axis_r_r_payload_id;
    logic [1:0]   axis_r_r_payload_resp;
    logic         axis_r_r_payload_last;
    logic         axis_w_aw_valid, axis_w_aw_ready;
    logic [31:0]  axis_w_aw_payload_addr;
    logic [5:0]   axis_w_aw_payload_id;
    logic [7:0]   axis_w_aw_payload_len;
    logic [1:0]   axis_w_aw_payload_burst;
    logic         axis_w_w_valid, axis_w_w_ready;
    logic [255:0] axis_w_w_payload_data;
    logic [31:0]  axis_w_w_payload_strb;
    logic         axis_w_w_payload_last;
    logic         axis_w_b_valid, axis_w_b_ready;
    logic [5:0]   axis_w_b_payload_id;
    logic [1:0]   axis_w_b_payload_resp;

    axi_mem_param dut (
        .clk(clk), .reset(reset),
        .axis_r_ar_valid(axis_r_ar_valid), .axis_r_ar_ready(axis_r_ar_ready),
        .axis_r_ar_payload_addr(axis_r_ar_payload_addr), .axis_r_ar_payload_id(axis_r_ar_payload_id),
        .axis_r_ar_payload_len(axis_r_ar_payload_len), .axis_r_ar_payload_burst(axis_r_ar_payload_burst),
        .axis_r_r_valid(axis_r_r_valid), .axis_r_r_ready(axis_r_r_ready),
        .axis_r_r_payload_data(axis_r_r_payload_data), .axis_r_r_payload_id(axis_r_r_payload_id),
        .axis_r_r_payload_resp(axis_r_r_payload_resp), .axis_r_r_payload_last(axis_r_r_payload_last),
        .axis_w_aw_valid(axis_w_aw_valid), .axis_w_aw_ready(axis_w_aw_ready),
        .axis_w_aw_payload_addr(axis_w_aw_payload_addr), .axis_w_aw_payload_id(axis_w_aw_payload_id),
        .axis_w_aw_payload_len(axis_w_aw_payload_len), .axis_w_aw_payload_burst(axis_w_aw_payload_burst),
        .axis_w_w_valid(axis_w_w_valid), .axis_w_w_ready(axis_w_w_ready),
        .axis_w_w_payload_data(axis_w_w_payload_data), .axis_w_w_payload_strb(axis_w_w_payload_strb),
        .axis_w_w_payload_last(axis_w_w_payload_last),
        .axis_w_b_valid(axis_w_b_valid), .axis_w_b_ready(axis_w_b_ready),
        .axis_w_b_payload_id(axis_w_b_payload_id), .axis_w_b_payload_resp(axis_w_b_payload_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [1:0]       burst;
        logic [3:0][15:0] wd;
        logic [3:0][1:0]  rs;
    } rvec_t;

    int checks = 0;
    int failures = 0;
    logic [255:0] got_data [0:15];
    logic [1:0]   got_resp [0:15];
    logic         got_last [0:15];
    logic [5:0]   got_id   [0:15];
    logic [255:0] wr_data  [0:15];
    logic [31:0]  wr_strb  [0:15];
    logic         wr_last  [0:15];

    function automatic logic [255:0] pat(input int w);
        logic [255:0] p;
        for (int l = 0; l < 8; l++) p[l*32 +: 32] = 32'hA500_0000 + 32'(w << 8) + 32'(l);
        return p;
    endfunction

    function automatic rvec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                                 input int w0, input int w1, input int w2, input int w3,
                                 input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] r2, input logic [1:0] r3);
        rvec_t v;
        v.addr = a; v.len = l; v.burst = b;
        v.wd[0] = 16'(w0); v.wd[1] = 16'(w1); v.wd[2] = 16'(w2); v.wd[3] = 16'(w3);
        v.rs[0] = r0; v.rs[1] = r1; v.rs[2] = r2; v.rs[3] = r3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                           input logic [5:0] id);
        int n;
        @(negedge clk);
        axis_r_ar_payload_addr = a; axis_r_ar_payload_len = l;
        axis_r_ar_payload_burst = b; axis_r_ar_payload_id = id; axis_r_ar_valid = 1'b1;
        n = 0;
        while (axis_r_ar_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chki("ar_accept", int'(n < 50), 1);
        @(posedge clk); #1 axis_r_ar_valid = 1'b0;
    endtask

    task automatic collect(input int nb, input logic [3:0] rdy_pat, output int hs, output int hold_err);
        logic stalled, pl;
        logic [255:0] pd;
        hs = 0; hold_err = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
        for (int c = 0; c < 400 && hs < nb; c++) begin
            @(negedge clk);
            if (stalled && (axis_r_r_valid !== 1'b1 || axis_r_r_payload_data !== pd ||
                            axis_r_r_payload_last !== pl)) hold_err++;
            axis_r_r_ready = rdy_pat[c % 4];
            if (axis_r_r_valid && axis_r_r_ready) begin
                got_data[hs] = axis_r_r_payload_data; got_resp[hs] = axis_r_r_payload_resp;
                got_last[hs] = axis_r_r_payload_last; got_id[hs] = axis_r_r_payload_id;
                hs++; stalled = 1'b0;
            end else begin
                stalled = axis_r_r_valid; pd = axis_r_r_payload_data; pl = axis_r_r_payload_last;
            end
        end
        @(posedge clk); #1 axis_r_r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                            input logic [5:0] id, input logic [1:0] exp_resp, input string nm);
        int n;
        @(negedge clk);
        axis_w_aw_payload_addr = a; axis_w_aw_payload_len = l;
        axis_w_aw_payload_burst = b; axis_w_aw_payload_id = id; axis_w_aw_valid = 1'b1;
        n = 0;
        while (axis_w_aw_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chki({nm, "_aw_accept"}, int'(n < 50), 1);
        @(posedge clk); #1 axis_w_aw_valid = 1'b0;
        for (int k = 0; k <= int'(l); k++) begin
            @(negedge clk);
            axis_w_w_valid = 1'b1; axis_w_w_payload_data = wr_data[k];
            axis_w_w_payload_strb = wr_strb[k]; axis_w_w_payload_last = wr_last[k];
            n = 0;
            while (axis_w_w_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chki($sformatf("%s_w%0d_accept", nm, k), int'(n < 50), 1);
            @(posedge clk); #1;
        end
        axis_w_w_valid = 1'b0; axis_w_w_payload_last = 1'b0;
        @(negedge clk);
        axis_w_b_ready = 1'b1;
        n = 0;
        while (axis_w_b_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chki({nm, "_b_seen"}, int'(n < 50), 1);
        chki({nm, "_bid"}, int'(axis_w_b_payload_id), int'(id));
        chki({nm, "_bresp"}, int'(axis_w_b_payload_resp), int'(exp_resp));
        @(posedge clk); #1 axis_w_b_ready = 1'b0;
    endtask

    task automatic fill(input int nb, input int base, input logic invert, input int last_at);
        for (int k = 0; k < nb; k++) begin
            wr_data[k] = invert ? ~pat(base + k) : pat(base + k);
            wr_strb[k] = 32'hFFFF_FFFF;
            wr_last[k] = (k == last_at);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    rvec_t        vt [9];
    int           hs, he, extra;
    logic [255:0] d_single, e, ta, tb2;

    initial begin
        reset = 1'b1;
        axis_r_ar_valid = 1'b0; axis_r_ar_payload_addr = '0; axis_r_ar_payload_id = '0;
        axis_r_ar_payload_len = '0; axis_r_ar_payload_burst = '0; axis_r_r_ready = 1'b0;
        axis_w_aw_valid = 1'b0; axis_w_aw_payload_addr = '0; axis_w_aw_payload_id = '0;
        axis_w_aw_payload_len = '0; axis_w_aw_payload_burst = '0; axis_w_w_valid = 1'b0;
        axis_w_w_payload_data = '0; axis_w_w_payload_strb = '0; axis_w_w_payload_last = 1'b0;
        axis_w_b_ready = 1'b0;

        vt[0] = mk(32'h40,    8'd3, 2'd2, 2, 3, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        vt[1] = mk(32'h40,    8'd2, 2'd2, 2, 3, 4, 0, 2'd2, 2'd2, 2'd2, 2'd0);
        vt[2] = mk(32'h1FFE0, 8'd1, 2'd1, 4095, 4096, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0);
        vt[3] = mk(32'h60,    8'd2, 2'd0, 3, 3, 3, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        vt[4] = mk(32'h20,    8'd3, 2'd1, 1, 2, 3, 4, 2'd0, 2'd0, 2'd0, 2'd0);
        vt[5] = mk(32'hA0,    8'd1, 2'd3, 5, 6, 0, 0, 2'd2, 2'd2, 2'd0, 2'd0);
        vt[6] = mk(32'h60,    8'd1, 2'd2, 3, 2, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        vt[7] = mk(32'hE0,    8'd0, 2'd1, 7, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
        vt[8] = mk(32'h20000, 8'd0, 2'd1, 4096, 0, 0, 0, 2'd2, 2'd0, 2'd0, 2'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chki("rst_ar_ready", int'(axis_r_ar_ready), 0);
        chki("rst_aw_ready", int'(axis_w_aw_ready), 0);
        chki("rst_r_valid", int'(axis_r_r_valid), 0);
        chki("rst_b_valid", int'(axis_w_b_valid), 0);
        chk("rst_r_data", axis_r_r_payload_data, '0);
        reset = 1'b0;
        @(negedge clk);
        chki("idle_ar_ready", int'(axis_r_ar_ready), 1);
        chki("idle_aw_ready", int'(axis_w_aw_ready), 1);

        // single-beat write then read back
        d_single = {4{64'h0123_4567_89AB_CDEF}};
        wr_data[0] = d_single; wr_strb[0] = 32'hFFFF_FFFF; wr_last[0] = 1'b1;
        do_write(32'h40, 8'd0, 2'd1, 6'h2A, 2'd0, "single");
        ar_send(32'h40, 8'd0, 2'd1, 6'h15);
        collect(1, 4'b1111, hs, he);
        chki("single_rd_beats", hs, 1);
        chk("single_rd_data", got_data[0], d_single);
        chki("single_rd_last", int'(got_last[0]), 1);
        chki("single_rd_resp", int'(got_resp[0]), 0);
        chki("single_rd_id", int'(got_id[0]), 'h15);

        // preload words 0..7 and DEPTH-1, and an out-of-range write
        fill(8, 0, 1'b0, 7);
        do_write(32'h0, 8'd7, 2'd1, 6'h01, 2'd0, "init");
        fill(1, 4095, 1'b0, 0);
        do_write(32'h1FFE0, 8'd0, 2'd1, 6'h02, 2'd0, "init_top");
        fill(2, 900, 1'b0, 1);
        do_write(32'h20000, 8'd1, 2'd1, 6'h03, 2'd2, "wr_oor");

        for (int i = 0; i < 9; i++) begin
            ar_send(vt[i].addr, vt[i].len, vt[i].burst, 6'(i + 1));
            collect(int'(vt[i].len) + 1, 4'b1111, hs, he);
            chki($sformatf("v%0d_beats", i), hs, int'(vt[i].len) + 1);
            for (int b = 0; b <= int'(vt[i].len); b++) begin
                e = (int'(vt[i].wd[b]) >= DEPTH) ? '0 : pat(int'(vt[i].wd[b]));
                chk($sformatf("v%0d_b%0d_data", i, b), got_data[b], e);
                chki($sformatf("v%0d_b%0d_resp", i, b), int'(got_resp[b]), int'(vt[i].rs[b]));
                chki($sformatf("v%0d_b%0d_last", i, b), int'(got_last[b]), int'(b == int'(vt[i].len)));
                chki($sformatf("v%0d_b%0d_id", i, b), int'(got_id[b]), i + 1);
            end
        end

        // 8-beat read with r_ready pattern 1,0,0,1
        ar_send(32'h0, 8'd7, 2'd1, 6'h09);
        collect(8, 4'b1001, hs, he);
        chki("bp_handshakes", hs, 8);
        chki("bp_hold_errors", he, 0);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("bp_b%0d_data", b), got_data[b], pat(b));
            chki($sformatf("bp_b%0d_last", b), int'(got_last[b]), int'(b == 7));
        end
        axis_r_r_ready = 1'b1; extra = 0;
        repeat (4) begin @(negedge clk); if (axis_r_r_valid) extra++; end
        axis_r_r_ready = 1'b0;
        chki("bp_extra_beats", extra, 0);

        // strobed INCR: beat 2 updates only its low 4 bytes
        fill(4, 0, 1'b1, 3);
        wr_strb[2] = 32'h0000_000F;
        do_write(32'h0, 8'd3, 2'd1, 6'h04, 2'd0, "strb");
        ar_send(32'h0, 8'd3, 2'd1, 6'h05);
        collect(4, 4'b1111, hs, he);
        chki("strb_beats", hs, 4);
        for (int b = 0; b < 4; b++) begin
            ta = pat(b); tb2 = ~pat(b);
            e = (b == 2) ? {ta[255:32], tb2[31:0]} : tb2;
            chk($sformatf("strb_b%0d_data", b), got_data[b], e);
        end

        // w_last early on beat 1 of len 3: all 4 beats still land, SLVERR
        fill(4, 100, 1'b0, 1);
        do_write(32'h100, 8'd3, 2'd1, 6'h06, 2'd2, "wlast");
        ar_send(32'h100, 8'd3, 2'd1, 6'h07);
        collect(4, 4'b1111, hs, he);
        chki("wlast_rd_beats", hs, 4);
        for (int b = 0; b < 4; b++)
            chk($sformatf("wlast_b%0d_data", b), got_data[b], pat(100 + b));

        // reset during W_DATA aborts silently
        @(negedge clk);
        axis_w_aw_payload_addr = 32'h200; axis_w_aw_payload_len = 8'd3;
        axis_w_aw_payload_burst = 2'd1; axis_w_aw_payload_id = 6'h08; axis_w_aw_valid = 1'b1;
        @(posedge clk); #1 axis_w_aw_valid = 1'b0;
        @(negedge clk);
        axis_w_w_valid = 1'b1; axis_w_w_payload_data = pat(50);
        axis_w_w_payload_strb = 32'hFFFF_FFFF; axis_w_w_payload_last = 1'b0;
        @(posedge clk); #1 axis_w_w_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chki("midrst_b_valid", int'(axis_w_b_valid), 0);
        chki("midrst_aw_ready", int'(axis_w_aw_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chki("postrst_aw_ready", int'(axis_w_aw_ready), 1);
        repeat (3) @(negedge clk);
        chki("postrst_b_valid", int'(axis_w_b_valid), 0);
        fill(1, 60, 1'b0, 0);
        do_write(32'h200, 8'd0, 2'd1, 6'h0A, 2'd0, "postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
